otter_csr_intr: RTL and testbench



---
 rtl/otter_csr_pkg.sv | 41 ++++
 rtl/intr_sync_edge.sv | 27 ++
 rtl/otter_csr_intr.sv | 116 +++++++++++
 tb/tb_otter_csr_intr.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/otter_csr_pkg.sv
// Shared definitions for the OTTER machine-mode CSR file and interrupt front-end.
package otter_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  typedef enum logic [2:0] {
    CSRRW = 3'b001,
    CSRRS = 3'b010,
    CSRRC = 3'b011
  } csr_op_e;

  typedef enum logic {
    PEND_IDLE = 1'b0,
    PEND_SET  = 1'b1
  } pend_state_e;

  // Result of a csrrw/csrrs/csrrc on the old value; unsupported ops return old.
  function automatic logic [31:0] csr_apply(input logic [2:0] op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] operand);
    logic [31:0] res;
    res = old_val;
    case (op)
      CSRRW:   res = operand;
      CSRRS:   res = old_val | operand;
      CSRRC:   res = old_val & ~operand;
      default: res = old_val;
    endcase
    return res;
  endfunction

  function automatic logic csr_op_valid(input logic [2:0] op);
    return (op == CSRRW) || (op == CSRRS) || (op == CSRRC);
  endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// Synchronises an asynchronous level input into clk and emits a one-cycle
// pulse on each synchronised rising edge.
module intr_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic RST_N,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~delay_q;

endmodule

// File: rtl/otter_csr_intr.sv
// Machine-mode CSRs (mstatus/mtvec/mepc) and external interrupt pending logic
// for the OTTER multicycle core.
//
//   state     | meaning
//   PEND_IDLE | no external interrupt waiting
//   PEND_SET  | synchronised rising edge seen, not yet taken by the FSM
module otter_csr_intr
  import otter_csr_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        intr_in,
  input  logic        csr_WE,
  input  logic        int_taken,
  input  logic        mret_exec,
  input  logic [2:0]  func3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] wd,
  input  logic [31:0] pc,
  output logic [31:0] rd,
  output logic [31:0] mepc,
  output logic [31:0] mtvec,
  output logic        intr,
  output logic        mie
);

  logic        mie_q;
  logic        mpie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mstatus_rd;
  logic [31:0] new_val;
  logic        wr_en;
  logic        rise;

  pend_state_e pend_q;
  pend_state_e pend_d;

  intr_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .RST_N(RST_N),
    .din  (intr_in),
    .rise (rise)
  );

  always_comb begin
    mstatus_rd           = '0;
    mstatus_rd[MIE_BIT]  = mie_q;
    mstatus_rd[MPIE_BIT] = mpie_q;
  end

  always_comb begin
    rd = '0;
    case (csr_addr)
      CSR_MSTATUS: rd = mstatus_rd;
      CSR_MTVEC:   rd = mtvec_q;
      CSR_MEPC:    rd = mepc_q;
      default:     rd = '0;
    endcase
  end

  // Interrupt entry and mret both outrank a CSR write in the same cycle.
  assign new_val = csr_apply(func3, rd, wd);
  assign wr_en   = csr_WE & csr_op_valid(func3) & ~int_taken & ~mret_exec;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
      mtvec_q <= '0;
      mepc_q  <= '0;
    end else if (int_taken) begin
      mepc_q <= pc & 32'hFFFF_FFFC;
      mpie_q <= mie_q;
      mie_q  <= 1'b0;
    end else if (mret_exec) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_q  <= new_val[MIE_BIT];
          mpie_q <= new_val[MPIE_BIT];
        end
        CSR_MTVEC: mtvec_q <= new_val;
        CSR_MEPC:  mepc_q  <= new_val & 32'hFFFF_FFFC;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) pend_q <= PEND_IDLE;
    else        pend_q <= pend_d;
  end

  // A fresh edge wins over int_taken so it is not lost in the entry cycle.
  always_comb begin
    pend_d = pend_q;
    case (pend_q)
      PEND_IDLE: if (rise) pend_d = PEND_SET;
      PEND_SET:  if (int_taken && !rise) pend_d = PEND_IDLE;
      default:   pend_d = PEND_IDLE;
    endcase
  end

  assign intr  = (pend_q == PEND_SET) & mie_q;
  assign mie   = mie_q;
  assign mepc  = mepc_q;
  assign mtvec = mtvec_q;

endmodule

// File: tb/tb_otter_csr_intr.sv
// Directed-vector bench for otter_csr_intr with immediate-assertion checks.
module tb_otter_csr_intr;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        intr_in;
  logic        csr_WE;
  logic        int_taken;
  logic        mret_exec;
  logic [2:0]  func3;
  logic [11:0] csr_addr;
  logic [31:0] wd;
  logic [31:0] pc;
  logic [31:0] rd;
  logic [31:0] mepc;
  logic [31:0] mtvec;
  logic        intr;
  logic        mie;

  int vectors    = 0;
  int miscompares = 0;

  otter_csr_intr #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .RST_N    (RST_N),
    .intr_in  (intr_in),
    .csr_WE   (csr_WE),
    .int_taken(int_taken),
    .mret_exec(mret_exec),
    .func3    (func3),
    .csr_addr (csr_addr),
    .wd       (wd),
    .pc       (pc),
    .rd       (rd),
    .mepc     (mepc),
    .mtvec    (mtvec),
    .intr     (intr),
    .mie      (mie)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] v);
    csr_WE = 1'b1; func3 = f3; csr_addr = a; wd = v;
    cyc();
    csr_WE = 1'b0; wd = '0;
    #1;
  endtask

  initial begin
    RST_N = 1'b0; intr_in = 1'b0; csr_WE = 1'b0; int_taken = 1'b0; mret_exec = 1'b0;
    func3 = 3'b000; csr_addr = 12'h300; wd = '0; pc = '0;
    cyc(); cyc();
    chk("rst_mtvec", mtvec, 32'h0);
    chk("rst_mepc", mepc, 32'h0);
    chk("rst_intr", {31'b0, intr}, 32'h0);
    chk("rst_mie", {31'b0, mie}, 32'h0);
    chk("rst_rd_mstatus", rd, 32'h0);
    RST_N = 1'b1;
    cyc();

    // csrrw mtvec: rd shows old value in the write cycle
    csr_WE = 1'b1; func3 = 3'b001; csr_addr = 12'h305; wd = 32'h0000_0200;
    #1 chk("csrrw_rd_old", rd, 32'h0);
    cyc(); csr_WE = 1'b0; #1;
    chk("csrrw_mtvec", mtvec, 32'h200);
    chk("rd_mtvec", rd, 32'h200);

    csr_op(3'b010, 12'h300, 32'h8);
    chk("csrrs_mie", {31'b0, mie}, 32'h1);
    chk("rd_mstatus_8", rd, 32'h8);
    csr_op(3'b011, 12'h300, 32'h8);
    chk("csrrc_mie", {31'b0, mie}, 32'h0);
    csr_op(3'b001, 12'h341, 32'h1237);
    chk("mepc_align", mepc, 32'h1234);

    // func3=000 and 1xx must not write
    csr_op(3'b000, 12'h305, 32'hFFFF_FFFF);
    chk("f3_000_nowrite", mtvec, 32'h200);
    csr_op(3'b101, 12'h305, 32'hFFFF_FFFF);
    chk("f3_101_nowrite", mtvec, 32'h200);

    // unimplemented address
    csr_WE = 1'b1; func3 = 3'b001; csr_addr = 12'h7C0; wd = 32'hFFFF_FFFF;
    #1 chk("unimpl_rd", rd, 32'h0);
    cyc(); csr_WE = 1'b0; #1;
    chk("unimpl_mtvec", mtvec, 32'h200);
    chk("unimpl_mepc", mepc, 32'h1234);
    chk("unimpl_mie", {31'b0, mie}, 32'h0);

    // interrupt latency with MIE=1
    csr_op(3'b010, 12'h300, 32'h8);
    intr_in = 1'b1;
    cyc(); chk("lat_k", {31'b0, intr}, 32'h0);
    cyc(); chk("lat_k1", {31'b0, intr}, 32'h0);
    cyc(); chk("lat_k2", {31'b0, intr}, 32'h1);

    // interrupt entry with a coincident mtvec write that must be dropped
    int_taken = 1'b1; pc = 32'h0000_0042;
    csr_WE = 1'b1; func3 = 3'b001; csr_addr = 12'h305; wd = 32'h0000_DEAD;
    cyc(); int_taken = 1'b0; csr_WE = 1'b0; csr_addr = 12'h300; #1;
    chk("take_mepc", mepc, 32'h40);
    chk("take_mie", {31'b0, mie}, 32'h0);
    chk("take_intr", {31'b0, intr}, 32'h0);
    chk("take_mtvec_kept", mtvec, 32'h200);
    chk("take_mstatus", rd, 32'h80);

    // mret with a coincident mstatus clear that must be dropped
    mret_exec = 1'b1;
    csr_WE = 1'b1; func3 = 3'b001; csr_addr = 12'h300; wd = 32'h0;
    cyc(); mret_exec = 1'b0; csr_WE = 1'b0; #1;
    chk("mret_mie", {31'b0, mie}, 32'h1);
    chk("mret_mstatus", rd, 32'h88);
    cyc(); cyc(); cyc();
    chk("held_high_no_rearm", {31'b0, intr}, 32'h0);

    // re-arm after a low period
    intr_in = 1'b0;
    cyc(); cyc(); cyc();
    intr_in = 1'b1;
    cyc(); cyc();
    chk("rearm_early", {31'b0, intr}, 32'h0);
    cyc();
    chk("rearm_intr", {31'b0, intr}, 32'h1);

    // take it, then an edge while MIE=0 stays pending
    int_taken = 1'b1; pc = 32'h0000_0100;
    cyc(); int_taken = 1'b0; #1;
    chk("take2_mepc", mepc, 32'h100);
    intr_in = 1'b0;
    cyc(); cyc(); cyc();
    intr_in = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    chk("masked_intr", {31'b0, intr}, 32'h0);
    csr_op(3'b010, 12'h300, 32'h8);
    chk("unmask_intr", {31'b0, intr}, 32'h1);

    // new edge landing in the int_taken cycle remains pending
    intr_in = 1'b0;
    cyc(); cyc(); cyc();
    intr_in = 1'b1;
    cyc(); cyc();
    int_taken = 1'b1; pc = 32'h0000_0200;
    cyc(); int_taken = 1'b0; #1;
    chk("coinc_masked", {31'b0, intr}, 32'h0);
    csr_op(3'b010, 12'h300, 32'h8);
    chk("coinc_pending", {31'b0, intr}, 32'h1);

    // asynchronous reset mid-cycle with pending set
    intr_in = 1'b0;
    csr_addr = 12'h305;
    #1 RST_N = 1'b0;
    #2;
    chk("arst_mtvec", mtvec, 32'h0);
    chk("arst_mepc", mepc, 32'h0);
    chk("arst_intr", {31'b0, intr}, 32'h0);
    chk("arst_mie", {31'b0, mie}, 32'h0);
    chk("arst_rd", rd, 32'h0);
    RST_N = 1'b1;
    cyc(); cyc(); cyc();
    csr_op(3'b010, 12'h300, 32'h8);
    chk("post_rst_mie", {31'b0, mie}, 32'h1);
    chk("post_rst_no_pending", {31'b0, intr}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
